// File: rtl/data_l1_arbiter.sv
// -----------------------------------------------------------------------------
// data_l1_arbiter
//
// Two-requester front end for a single-ported L1 data array. One access is in
// flight at a time and each access takes three cycles: IDLE (grant),
// ACCESS (array is driven), RESP (completion pulse back to the requester).
// When both requesters contend, the one that did not win last time is granted.
//
// Ports
//   clk, reset              clock and synchronous active-high reset
//   reqN_valid/write/addr/wdata   request from requester N (N = 0, 1)
//   reqN_ready              grant; handshake when valid && ready at a rising edge
//   rspN_valid/rdata        one-cycle completion pulse and read data to requester N
//   mem_mode                array mode, 1 = write (high for one cycle per write)
//   mem_waddr/mem_raddr     array write/read address
//   mem_wdata               array write data
//   mem_rdata               combinational array read data for mem_raddr
//   busy                    high whenever an access is in flight
// -----------------------------------------------------------------------------
module data_l1_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              last_grant;
    logic              winner;
    logic              any_valid;
    logic              handshake;

    logic              cap_write;
    logic              cap_id;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] rdata_q;

    // Round-robin choice. A lone valid requester always wins; on contention
    // the requester that was not granted last time goes first.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        winner    = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    // Next-state and per-state outputs. Everything defaults low and stays low
    // while reset is high, so an aborted write can never pulse mem_mode and no
    // grant or response leaks out during reset.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        mem_mode   = 1'b0;
        busy       = 1'b0;
        handshake  = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        req0_ready = (winner == 1'b0);
                        req1_ready = (winner == 1'b1);
                        handshake  = 1'b1;
                        state_next = ACCESS;
                    end
                end
                ACCESS: begin
                    busy       = 1'b1;
                    mem_mode   = cap_write;
                    state_next = RESP;
                end
                RESP: begin
                    busy       = 1'b1;
                    rsp0_valid = (cap_id == 1'b0);
                    rsp1_valid = (cap_id == 1'b1);
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers. The captured request is only loaded at a handshake,
    // which always moves the FSM into ACCESS, so the captured address/data
    // double as the array drive: valid during ACCESS and simply held
    // afterwards until the next grant. last_grant starts at 1 so requester 0
    // wins the first contention after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            cap_write  <= 1'b0;
            cap_id     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            rdata_q    <= '0;
        end else begin
            if (handshake) begin
                last_grant <= winner;
                cap_id     <= winner;
                cap_write  <= winner ? req1_write : req0_write;
                cap_addr   <= winner ? req1_addr  : req0_addr;
                cap_wdata  <= winner ? req1_wdata : req0_wdata;
            end
            if (state == ACCESS && !cap_write) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_waddr = cap_addr;
    assign mem_raddr = cap_addr;
    assign mem_wdata = cap_wdata;

    // Read data is only presented alongside its pulse, and writes return zero.
    assign rsp0_rdata = (rsp0_valid && !cap_write) ? rdata_q : '0;
    assign rsp1_rdata = (rsp1_valid && !cap_write) ? rdata_q : '0;

endmodule

// File: tb/tb_data_l1_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_l1_arbiter
//
// Drives data_l1_arbiter against a behavioural array and compares every output
// each cycle with a transaction-level reference: a request is granted, runs
// for two more cycles, and reads return whatever the most recently completed
// write to that word left in a reference copy of the array.
// -----------------------------------------------------------------------------
module tb_data_l1_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic              req0_valid, req0_write, req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid, req1_write, req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
    logic              mem_mode;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              busy;

    data_l1_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .mem_mode   (mem_mode),
        .mem_waddr  (mem_waddr),
        .mem_raddr  (mem_raddr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural array: combinational read, written at the edge while
    // mem_mode is high. mem_fill preloads a known pattern once at start-up.
    logic              mem_fill;
    logic [DATA_W-1:0] env_mem [DEPTH];

    assign mem_rdata = env_mem[mem_raddr];

    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < DEPTH; i++) begin
                env_mem[i] <= DATA_W'(i * 16'h1357) ^ 16'hA5C3;
            end
        end else if (mem_mode) begin
            env_mem[mem_waddr] <= mem_wdata;
        end
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                m_age;
    logic              m_last;
    logic              m_write;
    logic              m_id;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    int                checks;
    int                failures;
    int                obs_grants[$];
    logic [DATA_W-1:0] last_rsp1_rdata;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Whom the arbitration rule picks among the currently valid requesters.
    function automatic logic pickWinner(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return (last == 1'b1) ? 1'b0 : 1'b1;
        return v1 && !v0;
    endfunction

    // Compare all outputs against the model for the current cycle.
    task automatic checkCycle();
        logic w;
        logic any;
        logic e_r0, e_r1, e_busy, e_mode, e_v0, e_v1;
        logic [DATA_W-1:0] e_d;
        any    = req0_valid | req1_valid;
        w      = pickWinner(req0_valid, req1_valid, m_last);
        e_r0   = !reset && m_age == 0 && any && w == 1'b0;
        e_r1   = !reset && m_age == 0 && any && w == 1'b1;
        e_busy = !reset && m_age != 0;
        e_mode = !reset && m_age == 1 && m_write;
        e_v0   = !reset && m_age == 2 && m_id == 1'b0;
        e_v1   = !reset && m_age == 2 && m_id == 1'b1;
        e_d    = m_write ? '0 : m_rdata;
        checkOutput("req0_ready", 32'(req0_ready), 32'(e_r0));
        checkOutput("req1_ready", 32'(req1_ready), 32'(e_r1));
        checkOutput("busy", 32'(busy), 32'(e_busy));
        checkOutput("mem_mode", 32'(mem_mode), 32'(e_mode));
        checkOutput("rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
        checkOutput("rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
        checkOutput("rsp0_rdata", 32'(rsp0_rdata), 32'(e_v0 ? e_d : '0));
        checkOutput("rsp1_rdata", 32'(rsp1_rdata), 32'(e_v1 ? e_d : '0));
        checkOutput("mem_waddr", 32'(mem_waddr), 32'(m_addr));
        checkOutput("mem_raddr", 32'(mem_raddr), 32'(m_addr));
        checkOutput("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        if (!reset && req0_valid && req0_ready) obs_grants.push_back(0);
        if (!reset && req1_valid && req1_ready) obs_grants.push_back(1);
        if (rsp1_valid) last_rsp1_rdata = rsp1_rdata;
    endtask

    // Advance the model across the coming rising edge.
    task automatic updateModel();
        logic w;
        if (reset) begin
            m_age   = 0;
            m_last  = 1'b1;
            m_write = 1'b0;
            m_id    = 1'b0;
            m_addr  = '0;
            m_wdata = '0;
            m_rdata = '0;
        end else if (m_age == 0) begin
            if (req0_valid || req1_valid) begin
                w       = pickWinner(req0_valid, req1_valid, m_last);
                m_last  = w;
                m_id    = w;
                m_write = w ? req1_write : req0_write;
                m_addr  = w ? req1_addr  : req0_addr;
                m_wdata = w ? req1_wdata : req0_wdata;
                m_age   = 1;
            end
        end else if (m_age == 1) begin
            if (m_write) ref_mem[m_addr] = m_wdata;
            else         m_rdata = ref_mem[m_addr];
            m_age = 2;
        end else begin
            m_age = 0;
        end
    endtask

    // One cycle: drive inputs after the falling edge, check, then model the edge.
    task automatic applyStimulus(input logic rst,
                                 input logic v0, input logic w0,
                                 input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                                 input logic v1, input logic w1,
                                 input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        @(negedge clk);
        reset      = rst;
        req0_valid = v0;
        req0_write = w0;
        req0_addr  = a0;
        req0_wdata = d0;
        req1_valid = v1;
        req1_write = w1;
        req1_addr  = a1;
        req1_wdata = d1;
        #1;
        checkCycle();
        updateModel();
        @(posedge clk);
        mem_fill = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic resetCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        last_rsp1_rdata = '0;
        mem_fill        = 1'b1;
        reset           = 1'b1;
        req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DATA_W'(i * 16'h1357) ^ 16'hA5C3;
        m_age = 0; m_last = 1'b1; m_write = 0; m_id = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;

        resetCycles(2);

        // Write then read back the same word from the other requester.
        applyStimulus(1'b0, 1, 1, 5'd3, 16'hBEEF, 0, 0, '0, '0);
        idleCycles(2);
        applyStimulus(1'b0, 0, 0, '0, '0, 1, 0, 5'd3, 16'h0000);
        idleCycles(3);
        checkOutput("rd_after_wr", 32'(last_rsp1_rdata), 32'h0000BEEF);

        // Both hold valid after reset: grants alternate starting with 0.
        resetCycles(1);
        obs_grants.delete();
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b0, 1, 0, 5'(i), '0, 1, 0, 5'(i + 7), '0);
        checkOutput("rr_count", 32'(obs_grants.size()), 32'd4);
        if (obs_grants.size() == 4) begin
            checkOutput("rr_g0", 32'(obs_grants[0]), 32'd0);
            checkOutput("rr_g1", 32'(obs_grants[1]), 32'd1);
            checkOutput("rr_g2", 32'(obs_grants[2]), 32'd0);
            checkOutput("rr_g3", 32'(obs_grants[3]), 32'd1);
        end
        idleCycles(2);

        // req1 alone for three grants, then contention goes to req0.
        obs_grants.delete();
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b0, 0, 0, '0, '0, 1, 0, 5'(i), '0);
        applyStimulus(1'b0, 1, 0, 5'd1, '0, 1, 0, 5'd2, '0);
        checkOutput("solo_then_contend", 32'(obs_grants.size() == 4 ? obs_grants[3] : 9), 32'd0);
        idleCycles(2);

        // Reset during ACCESS of a write aborts it; next contention goes to req0.
        applyStimulus(1'b0, 1, 1, 5'd7, 16'h7777, 0, 0, '0, '0);
        applyStimulus(1'b1, 0, 0, '0, '0, 0, 0, '0, '0);
        idleCycles(2);
        obs_grants.delete();
        applyStimulus(1'b0, 1, 0, 5'd7, '0, 1, 0, 5'd7, '0);
        checkOutput("post_abort_grant", 32'(obs_grants.size() == 1 ? obs_grants[0] : 9), 32'd0);
        idleCycles(3);

        // Inputs change right after the handshake; the array keeps the capture.
        applyStimulus(1'b0, 1, 1, 5'd9, 16'h1234, 0, 0, '0, '0);
        applyStimulus(1'b0, 1, 1, 5'd22, 16'hDEAD, 0, 0, '0, '0);
        idleCycles(3);
        applyStimulus(1'b0, 0, 0, '0, '0, 1, 0, 5'd9, '0);
        idleCycles(3);
        checkOutput("capture_hold", 32'(last_rsp1_rdata), 32'h00001234);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 9) < 6), 1'($urandom),
                          ADDR_W'($urandom), DATA_W'($urandom),
                          ($urandom_range(0, 9) < 6), 1'($urandom),
                          ADDR_W'($urandom), DATA_W'($urandom));
        end
        idleCycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_l1_arbiter.md
DATA_L1_ARBITER -- requirements
Module: data_l1_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, word address width of the L1 data array.
REQ-002 Parameter DATA_W, default 16, data word width of the L1 data array.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester n has a pending access.
REQ-006 req0_write / req1_write  input  1  1 = write, 0 = read.
REQ-007 req0_addr / req1_addr  input  ADDR_W  word address.
REQ-008 req0_wdata / req1_wdata  input  DATA_W  write data.
REQ-009 req0_ready / req1_ready  output  1  grant; handshake completes when valid and ready are both high at a rising edge.
REQ-010 rsp0_valid / rsp1_valid  output  1  one-cycle completion pulse to requester n.
REQ-011 rsp0_rdata / rsp1_rdata  output  DATA_W  read data, valid only while rspn_valid is high.
REQ-012 mem_mode  output  1  array mode: 0 = read, 1 = write.
REQ-013 mem_waddr / mem_raddr  output  ADDR_W  array write and read addresses.
REQ-014 mem_wdata  output  DATA_W  array write data.
REQ-015 mem_rdata  input  DATA_W  array combinational read data for mem_raddr.
REQ-016 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and RESP, with transitions IDLE->ACCESS on handshake, ACCESS->RESP always, and RESP->IDLE always.
REQ-018 In IDLE, ready SHALL be asserted combinationally to exactly one valid requester, the arbitration winner; both ready outputs SHALL be 0 in ACCESS and RESP.
REQ-019 Arbitration SHALL be round-robin with a one-bit last_grant register: if only one requester is valid it wins; if both are valid, the requester not equal to last_grant wins.
REQ-020 last_grant SHALL update to the winner index on each handshake and only then.
REQ-021 On handshake, the controller SHALL capture write, addr, wdata and the winner ID into internal registers; later requester input changes SHALL NOT affect the captured access.
REQ-022 In ACCESS, mem_waddr, mem_raddr and mem_wdata SHALL be driven from the captured values, and mem_mode SHALL be 1 if the access is a write, else 0.
REQ-023 mem_mode SHALL be 0 in every state other than ACCESS-with-write, so it is high for exactly one cycle per write.
REQ-024 In ACCESS for a read, mem_rdata SHALL be registered at the rising edge leaving ACCESS.
REQ-025 In RESP, rspn_valid SHALL be 1 for exactly one cycle, only for the captured requester; the other requester's rsp_valid SHALL remain 0.
REQ-026 rspn_rdata SHALL carry the registered read data for a read and all zeros for a write.
REQ-027 rsp_rdata SHALL be all zeros whenever its rsp_valid is 0.
REQ-028 Latency SHALL be exactly 2 cycles from the handshake edge to the rsp_valid cycle.
REQ-029 Throughput SHALL be one access per 3 cycles; a requester holding valid is re-arbitrated in the next IDLE cycle.
REQ-030 Accesses SHALL complete in grant order, so a read issued after a write to the same address, by either requester, SHALL return the written data.
REQ-031 Addresses SHALL be used unmodified with no wrap or range check; all ADDR_W values 0..2^ADDR_W-1 are legal.
REQ-032 Outside ACCESS, mem_waddr, mem_raddr and mem_wdata SHALL hold their last driven values.

Reset
REQ-033 When reset is high at a rising edge: state becomes IDLE, last_grant becomes 1 (requester 0 wins the first contention), the captured registers and read-data register become 0, and mem_waddr, mem_raddr and mem_wdata become 0.
REQ-034 While reset is high: all ready, rsp_valid, mem_mode and busy outputs SHALL be 0, and rsp_rdata SHALL be 0.
REQ-035 Reset asserted in ACCESS or RESP SHALL abort the access with no rsp_valid pulse; a write aborted in ACCESS SHALL NOT drive mem_mode high after the reset edge.

Verification
REQ-036 Reset, then req0 writes 16'hBEEF to address 3 -> req0_ready high in IDLE, mem_mode=1 for one cycle with mem_waddr=3, rsp0_valid 2 cycles after handshake with rsp0_rdata=0.
REQ-037 Then req1 reads address 3 -> mem_mode=0 and mem_raddr=3 in ACCESS, rsp1_valid with rsp1_rdata=16'hBEEF, rsp0_valid stays 0.
REQ-038 Both requesters hold valid for 4 grants straight after reset -> grant order 0,1,0,1, with one rsp pulse every 3 cycles.
REQ-039 req1 alone valid for 3 grants -> req1 granted each IDLE, then req0 and req1 both valid -> req0 wins (last_grant=1).
REQ-040 Assert reset during ACCESS of a req0 write to address 7 -> no rsp0_valid, mem_mode=0, busy=0, state IDLE, next contention granted to req0.
REQ-041 Change req0_addr and req0_wdata in the cycle after handshake -> the array sees the originally captured values.
